// File: rtl/hub75_pkg.sv
// hub75_pkg: shared defaults, FSM state type and write-word layout for the
// HUB75 capture block.
package hub75_pkg;

  localparam int unsigned NUM_COLS_DEF  = 64;
  localparam int unsigned NUM_ROWS_DEF  = 64;
  localparam int unsigned BIT_DEPTH_DEF = 3;

  // Pixels in one half of the panel (upper or lower data lane).
  function automatic int unsigned half_screen(input int unsigned cols, input int unsigned rows);
    return cols * rows / 2;
  endfunction

  localparam int unsigned HALF_SCREEN = half_screen(NUM_COLS_DEF, NUM_ROWS_DEF);

  typedef enum logic {
    ST_IDLE,
    ST_DUMP
  } state_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [1:0]  plane;
    logic [2:0]  rgb;
  } wr_word_t;

endpackage

// File: rtl/hub75_sync.sv
// hub75_sync: two-flop synchronizer for the HUB75 input bundle plus rising-edge
// detection of hub_clk and latch. Data and row travel in the same flops as the
// strobes so they stay aligned with the detected edges.
module hub75_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       hub_clk,
  input  logic       latch,
  input  logic [5:0] data,
  input  logic [4:0] row,
  output logic       hub_rise,
  output logic       latch_rise,
  output logic [5:0] data_s,
  output logic [4:0] row_s
);

  logic [12:0] meta_q;
  logic [12:0] sync_q;
  logic        hub_prev_q;
  logic        latch_prev_q;

  // Synchronizer chain and previous-value flops for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q       <= '0;
      sync_q       <= '0;
      hub_prev_q   <= 1'b0;
      latch_prev_q <= 1'b0;
    end else begin
      meta_q       <= {hub_clk, latch, data, row};
      sync_q       <= meta_q;
      hub_prev_q   <= sync_q[12];
      latch_prev_q <= sync_q[11];
    end
  end

  // Single-cycle rising-edge strobes and aligned data/row.
  always_comb begin
    hub_rise   = sync_q[12] & ~hub_prev_q;
    latch_rise = sync_q[11] & ~latch_prev_q;
    data_s     = sync_q[10:5];
    row_s      = sync_q[4:0];
  end

endmodule

// File: rtl/hub75_capture.sv
// hub75_capture: captures HUB75 panel lines into a line register, and on each
// valid latch dumps the held line as per-pixel plane writes over a
// valid/ready interface. Define HUB75_CAPTURE_STATS_EN to add line_count and
// frame_count outputs.
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int unsigned NUM_COLS  = NUM_COLS_DEF,
  parameter int unsigned NUM_ROWS  = NUM_ROWS_DEF,
  parameter int unsigned BIT_DEPTH = BIT_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hub_clk,
  input  logic        R0,
  input  logic        G0,
  input  logic        B0,
  input  logic        R1,
  input  logic        G1,
  input  logic        B1,
  input  logic        latch,
  input  logic        blank,
  input  logic [4:0]  row,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [11:0] wr_addr,
  output logic [1:0]  wr_plane,
  output logic [2:0]  wr_rgb,
  output logic        err_len,
  output logic        err_ovr
`ifdef HUB75_CAPTURE_STATS_EN
  ,
  output logic [15:0] line_count,
  output logic [15:0] frame_count
`endif
);

  localparam int unsigned   HALF       = half_screen(NUM_COLS, NUM_ROWS);
  localparam int unsigned   CW         = $clog2(NUM_COLS + 1);
  localparam int unsigned   IW         = $clog2(2 * NUM_COLS);
  localparam logic [CW-1:0] COLS_FULL  = CW'(NUM_COLS);
  localparam logic [IW-1:0] IDX_LAST   = IW'(2 * NUM_COLS - 1);
  localparam logic [1:0]    PLANE_LAST = 2'(BIT_DEPTH - 1);

  logic          hub_rise;
  logic          latch_rise;
  logic [5:0]    data_s;
  logic [4:0]    row_s;

  logic [5:0]    line_q [NUM_COLS];
  logic [5:0]    hold_q [NUM_COLS];
  logic [CW-1:0] col_cnt_q;
  logic [IW-1:0] idx_q;
  logic [IW-2:0] col;
  logic [4:0]    row_q;
  logic [1:0]    plane_q;
  logic [1:0]    next_plane;
  logic          seen_q;
  logic          err_len_q;
  logic          err_ovr_q;
  logic          line_full;
  logic          take_latch;
  state_t        state_q;
  state_t        state_d;
  wr_word_t      word;

  logic          unused_blank;
  assign unused_blank = blank;

  hub75_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .hub_clk    (hub_clk),
    .latch      (latch),
    .data       ({R0, G0, B0, R1, G1, B1}),
    .row        (row),
    .hub_rise   (hub_rise),
    .latch_rise (latch_rise),
    .data_s     (data_s),
    .row_s      (row_s)
  );

  // Latch qualification and plane tracking for the next accepted line.
  always_comb begin
    line_full  = (col_cnt_q == COLS_FULL);
    take_latch = latch_rise && line_full && (state_q == ST_IDLE);
    if (!seen_q || row_s != row_q || plane_q == PLANE_LAST) begin
      next_plane = 2'd0;
    end else begin
      next_plane = plane_q + 2'd1;
    end
  end

  // Line register shifts toward index 0 so the first edge after a latch lands in column 0.
  always_ff @(posedge clk) begin
    if (hub_rise) begin
      for (int unsigned i = 0; i < NUM_COLS - 1; i++) begin
        line_q[i] <= line_q[i + 1];
      end
      line_q[NUM_COLS - 1] <= data_s;
    end
    if (take_latch) begin
      hold_q <= line_q;
    end
  end

  // Column counter, sticky errors, latched row/plane and dump index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= '0;
      idx_q     <= '0;
      row_q     <= '0;
      plane_q   <= '0;
      seen_q    <= 1'b0;
      err_len_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_rise) begin
        col_cnt_q <= '0;
      end else if (hub_rise && !line_full) begin
        col_cnt_q <= col_cnt_q + CW'(1);
      end
      if (latch_rise && !line_full) begin
        err_len_q <= 1'b1;
      end
      if (latch_rise && line_full && state_q == ST_DUMP) begin
        err_ovr_q <= 1'b1;
      end
      if (take_latch) begin
        row_q   <= row_s;
        plane_q <= next_plane;
        seen_q  <= 1'b1;
        idx_q   <= '0;
      end else if (wr_valid && wr_ready) begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  // Next state and write word; even index = upper half, odd index = lower half.
  always_comb begin
    state_d  = state_q;
    wr_valid = 1'b0;
    word     = '0;
    col      = idx_q[IW-1:1];
    if (state_q == ST_DUMP) begin
      wr_valid   = 1'b1;
      word.addr  = 12'(32'(row_q) * NUM_COLS + 32'(col) + (idx_q[0] ? HALF : 32'd0));
      word.plane = plane_q;
      word.rgb   = idx_q[0] ? hold_q[col][2:0] : hold_q[col][5:3];
      if (wr_ready && idx_q == IDX_LAST) begin
        state_d = ST_IDLE;
      end
    end else if (take_latch) begin
      state_d = ST_DUMP;
    end
    wr_addr  = word.addr;
    wr_plane = word.plane;
    wr_rgb   = word.rgb;
    err_len  = err_len_q;
    err_ovr  = err_ovr_q;
  end

`ifdef HUB75_CAPTURE_STATS_EN
  localparam logic [4:0] ROW_WRAP = 5'(NUM_ROWS / 2 - 1);

  // Line and frame statistics; a frame ends when row wraps back to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_count  <= '0;
      frame_count <= '0;
    end else begin
      if (latch_rise && line_full) begin
        line_count <= line_count + 16'd1;
      end
      if (take_latch && seen_q && row_s == '0 && row_q == ROW_WRAP) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end
`endif

endmodule
